// File: rtl/display7seg_scan_mux.sv
// Time-multiplexed hex 7-segment driver. A new value is staged in a shadow buffer
// and swapped into the display only at a frame wrap, which keeps digits from tearing.
module display7seg_scan_mux #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 256,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic                LOW      = (ACTIVE_LOW != 0);
    localparam logic [6:0]          SEG_OFF  = {7{LOW}};
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{LOW}};
    localparam logic [PW-1:0]       PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0]       BLK_LAST = BW'(BLINK_TICKS - 1);

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           blk_cnt_q, blk_cnt_d;
    logic                    phase_q, phase_d;
    logic [4*N_DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic [4*N_DIGITS-1:0]   act_val_q, act_val_d;
    logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic                    frame_done_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic                    upper_zero;
    logic                    blank;
    logic [N_DIGITS-1:0]     onehot;
    logic [6:0]              seg_lit;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0:    f = 7'h3F;
            4'h1:    f = 7'h06;
            4'h2:    f = 7'h5B;
            4'h3:    f = 7'h4F;
            4'h4:    f = 7'h66;
            4'h5:    f = 7'h6D;
            4'h6:    f = 7'h7D;
            4'h7:    f = 7'h07;
            4'h8:    f = 7'h7F;
            4'h9:    f = 7'h6F;
            4'hA:    f = 7'h77;
            4'hB:    f = 7'h7C;
            4'hC:    f = 7'h39;
            4'hD:    f = 7'h5E;
            4'hE:    f = 7'h79;
            default: f = 7'h71;
        endcase
        return f;
    endfunction

    always_comb begin
        tick = (pre_q == PRE_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        pre_d = tick ? '0 : pre_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        if (tick) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // A load coinciding with the wrap bypasses the shadow and goes straight to display.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;

        if (load) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
        end

        if (wrap) begin
            pending_d = 1'b0;
            if (load) begin
                act_val_d = value_in;
                act_dp_d  = dp_in;
            end else if (pending_q) begin
                act_val_d = shadow_val_q;
                act_dp_d  = shadow_dp_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Walk from the top digit down so each digit knows whether everything above it is zero.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        cur_lz     = 1'b0;
        upper_zero = 1'b1;
        onehot     = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (act_val_q[4*k +: 4] == 4'h0);
            if (idx_q == IW'(k)) begin
                cur_nib   = act_val_q[4*k +: 4];
                cur_dp    = act_dp_q[k];
                cur_blink = blink_mask[k];
                cur_lz    = upper_zero && (k != 0);
                onehot[k] = 1'b1;
            end
        end

        blank   = (blank_lz && cur_lz) || (phase_q && cur_blink);
        seg_lit = blank ? 7'h00 : hex_font(cur_nib);
        seg_d   = seg_lit ^ SEG_OFF;
        dp_d    = (cur_dp && !blank) ^ LOW;
        an_d    = onehot ^ AN_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            blk_cnt_q    <= '0;
            phase_q      <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= LOW;
            an_q         <= AN_OFF;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            blk_cnt_q    <= blk_cnt_d;
            phase_q      <= phase_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            frame_done_q <= wrap;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display7seg_scan_mux.sv
// Scoreboard bench for display7seg_scan_mux: a cycle-level reference model pushes the
// expected outputs for each clock edge; a monitor pops and compares them at the falling edge.
module tb_display7seg_scan_mux;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BT  = 2;
    localparam int FRAME = DIV * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    display7seg_scan_mux #(
        .N_DIGITS(N), .SCAN_DIV(DIV), .BLINK_TICKS(BT), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .seg_out(seg_out),
        .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned t = 0;

    logic [6:0]  font [16];
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_dpa, m_dps;
    bit          m_pend;

    int          m_idx, m_ticks;
    bit          m_phase, m_blank;
    logic [6:0]  m_lit;
    logic [3:0]  m_oh;
    exp_t        m_e;
    exp_t        mon_e;

    initial font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // Reference: position in the scan is pure arithmetic on the edge count since reset.
    always @(posedge clk) begin
        if (rst) begin
            t      = 0;
            m_act  = '0;
            m_sh   = '0;
            m_dpa  = '0;
            m_dps  = '0;
            m_pend = 1'b0;
        end else begin
            m_ticks = int'(t) / DIV;
            m_idx   = m_ticks % N;
            m_phase = ((m_ticks / BT) % 2) == 1;
            m_blank = (blank_lz && m_idx != 0 && (m_act >> (4 * m_idx)) == 16'h0)
                      || (m_phase && blink_mask[m_idx]);
            m_lit   = m_blank ? 7'h00 : font[(m_act >> (4 * m_idx)) & 16'hF];
            m_oh    = 4'b0001 << m_idx;
            m_e.seg = ~m_lit;
            m_e.dp  = ~(m_dpa[m_idx] && !m_blank);
            m_e.an  = ~m_oh;
            m_e.fd  = (t % FRAME) == FRAME - 1;
            exp_q.push_back(m_e);

            if (load) begin
                m_sh  = value_in;
                m_dps = dp_in;
            end
            if (m_e.fd) begin
                if (load) begin
                    m_act = value_in;
                    m_dpa = dp_in;
                end else if (m_pend) begin
                    m_act = m_sh;
                    m_dpa = m_dps;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            check("reset_seg", 16'(seg_out), 16'h7F);
            check("reset_dp", 16'(dp_out), 16'h1);
            check("reset_an", 16'(an_out), 16'hF);
            check("reset_fd", 16'(frame_done), 16'h0);
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("seg", 16'(seg_out), 16'(mon_e.seg));
            check("dp", 16'(dp_out), 16'(mon_e.dp));
            check("an", 16'(an_out), 16'(mon_e.an));
            check("frame_done", 16'(frame_done), 16'(mon_e.fd));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_slot(input int unsigned ph);
        int n;
        n = 0;
        while ((t % FRAME) != ph && n < 4 * FRAME) begin
            cyc(1);
            n++;
        end
        check("wait_slot_timeout", 16'(n >= 4 * FRAME), 16'h0);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(40);

        wait_slot(5);
        do_load(16'h12AF, 4'b0000);
        cyc(40);

        wait_slot(2);
        do_load(16'h1111, 4'b0001);
        cyc(3);
        do_load(16'h2222, 4'b0010);
        wait_slot(FRAME - 1);
        do_load(16'h3333, 4'b0100);
        cyc(36);

        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000);
        cyc(40);
        do_load(16'h0000, 4'b0000);
        cyc(40);
        blank_lz = 1'b0;

        blink_mask = 4'b0001;
        do_load(16'h8888, 4'b1111);
        cyc(80);
        blink_mask = 4'b0000;

        wait_slot(4);
        do_load(16'h5555, 4'b1010);
        cyc(2);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(40);

        repeat (500) begin
            load     = ($urandom_range(0, 7) == 0);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst  = 1'b0;
        load = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/display7seg_scan_mux.md
DISPLAY7SEG_SCAN_MUX -- requirements
Module: display7seg_scan_mux

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed hex digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot, legal range >= 2.
REQ-003 Parameter BLINK_TICKS, default 256: digit slots per blink half-period, legal range >= 1.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = segments, dp and anodes lit when driven 0; 0 = lit when driven 1.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 value_in  input  4*N_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
REQ-008 load  input  1  one-cycle request to capture value_in and dp_in.
REQ-009 dp_in  input  N_DIGITS  decimal-point request per digit, captured with load.
REQ-010 blank_lz  input  1  level; 1 = leading-zero blanking enabled.
REQ-011 blink_mask  input  N_DIGITS  level; 1 = digit blinks.
REQ-012 seg_out  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-013 dp_out  output  1  decimal point of the current digit, registered.
REQ-014 an_out  output  N_DIGITS  one-hot digit enable, registered.
REQ-015 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-016 Prescaler counts 0..SCAN_DIV-1 and wraps; tick = (count == SCAN_DIV-1).
REQ-017 On tick, digit index idx advances idx+1 mod N_DIGITS; frame wrap = tick with idx == N_DIGITS-1.
REQ-018 Load is double-buffered: load writes shadow <= {value_in, dp_in} and sets pending; the displayed register changes only at frame wrap (no tearing).
REQ-019 At frame wrap: if load is also high, active <= {value_in, dp_in} and pending <= 0; else if pending, active <= shadow and pending <= 0.
REQ-020 A load while pending is already set overwrites shadow; the last load before the wrap wins.
REQ-021 frame_done = 1 for exactly the cycle after each frame wrap, otherwise 0.
REQ-022 Segment decode is the logical "segment lit" pattern, inverted when ACTIVE_LOW=1: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex, bit6=g..bit0=a).
REQ-023 Leading-zero blanking, when blank_lz=1: digit k is blanked if all active nibbles k..N_DIGITS-1 are 0 and k != 0; digit 0 is never blanked by this rule.
REQ-024 Blink phase toggles every BLINK_TICKS ticks; while phase=1, digits with blink_mask bit set are blanked.
REQ-025 Blanked digit: all segments and dp unlit; an_out still enables that digit.
REQ-026 Outputs are registered and reflect idx, active, blank_lz and blink_mask from the previous cycle (latency 1 clk).
REQ-027 an_out enables exactly one digit (the one at idx); all other digits are disabled, with levels per ACTIVE_LOW.

Reset
REQ-028 While rst=1: prescaler=0; idx=0; active=0; shadow=0; pending=0; blink counter=0; phase=0; frame_done=0; seg_out, dp_out and an_out all unlit/disabled.
REQ-029 Reset asserted mid-frame or mid-pending discards shadow, pending and active content; the first cycle after release drives digit 0 with value 0 (subject to REQ-023/024).

Verification (bench uses N_DIGITS=4, SCAN_DIV=4, BLINK_TICKS=2, ACTIVE_LOW=1)
REQ-030 Reset release, no load -> an_out cycles 1110,1101,1011,0111 with a 4-clk dwell each; seg_out=7'h40 on digit 0; frame_done pulses every 16 clk.
REQ-031 Load 16'h12AF mid-frame -> display stays 0 until the next wrap, then shows digits F,A,2,1 (seg 0E,08,24,79); pending clears.
REQ-032 Two loads in one frame (16'h1111 then 16'h2222), then a load coinciding with the wrap (16'h3333) -> 16'h3333 is displayed from the next frame; 16'h2222 is never displayed.
REQ-033 blank_lz=1, value 16'h0050 -> digits 3 and 2 are blank (seg 7F), digit 1 shows 5 (12), digit 0 shows 0 (40); value 16'h0000 -> only digit 0 is lit.
REQ-034 blink_mask=4'b0001 -> digit 0 is blank on alternate pairs of ticks; the other digits are unaffected; dp is also blanked.
REQ-035 rst pulse while pending=1 -> all outputs are unlit during reset; after release the display shows 0 and the shadow is never applied.
